branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
- Sequences branch/JR resolution in the ID stage of the 5-stage MIPS pipeline.
- Waits for forwarded operands and evaluates the branch condition: equality in the same style as the ID comparator, plus sign tests.
- Stalls ID/IF for a fixed resolution cycle, then issues a single registered PC redirect.
- Sits between the hazard unit (operand-ready flags) and the NPC mux.

Parameters:
- DATA_W, 32, operand and PC width.
- MAX_WAIT, 15, consecutive WAIT cycles before the sticky watchdog error sets; 4-bit counter, legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- br_valid  in  1  ID stage holds a branch/JR this cycle.
- br_type  in  3  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6 JR, 7 reserved.
- rs_val  in  DATA_W  rs value after forwarding.
- rt_val  in  DATA_W  rt value after forwarding.
- rs_ready  in  1  rs value is final (no pending producer).
- rt_ready  in  1  rt value is final.
- target  in  DATA_W  PC+4+(sext(imm)<<2), computed in ID.
- hold_in  in  1  external pipeline freeze (e.g. MDU busy).
- stall_id  out  1  freeze PC and IF/ID.
- redirect  out  1  NPC mux selects redirect_pc this cycle.
- redirect_pc  out  DATA_W  registered branch/JR destination.
- wd_err  out  1  sticky watchdog flag.
- br_count  out  32  resolved-branch count (optional feature).
- taken_count  out  32  taken-branch count (optional feature).

Behaviour:
- Reset is synchronous and active-high: on a rising clk with reset=1, all state and outputs clear. Resulting values: state=IDLE, stall_id=0, redirect=0, redirect_pc=0, wd_err=0, wait counter=0, stat counters=0. Reset mid-WAIT or mid-EVAL abandons the branch and issues no redirect.
- Operand need per type:
  - BEQ/BNE need rs and rt.
  - BLEZ/BGTZ/BLTZ/BGEZ need rs only.
  - JR needs rs only.
  - Type 7 needs nothing and is always not-taken.
- States:
  - IDLE:
    - If br_valid and needed operands are ready: go to EVAL.
    - If br_valid and any needed operand is not ready: go to WAIT.
    - stall_id = br_valid (combinational), so the branch is held from its first ID cycle.
  - WAIT: stall_id=1; wait counter increments, saturating at 15; go to EVAL when needed operands become ready. When counter == MAX_WAIT, wd_err<=1 (sticky); WAIT continues.
  - EVAL: stall_id=1; the condition is computed from rs_val/rt_val this cycle.
    - Compare rules: eq = (rs_val==rt_val); neg = rs_val[DATA_W-1]; zero = (rs_val==0).
    - BEQ: eq. BNE: !eq. BLEZ: neg|zero. BGTZ: !neg&!zero. BLTZ: neg. BGEZ: !neg. JR: always taken.
    - Registered at the end of EVAL: taken_r, and redirect_pc <= (JR ? rs_val : target). The wait counter clears. Next state is REDIRECT.
  - REDIRECT: redirect=taken_r; stall_id=0; the branch leaves ID and the delay slot advances normally (delay slot always executes); next state IDLE. For a not-taken branch, redirect stays 0 and redirect_pc still updates.
- Latency: the branch occupies ID for 2 + (WAIT cycles). The redirect pulse is exactly 1 cycle.
- hold_in=1 freezes state, counters and registered outputs. stall_id is forced to 1 while hold_in=1. redirect is masked to 0 while hold_in=1 and reasserts when hold_in releases (state remains REDIRECT).
- br_valid dropping in WAIT or EVAL (external flush): return to IDLE, no redirect, counter clears.
- A branch arriving in ID the cycle after REDIRECT (i.e. in the delay slot) is treated as a new, independent branch.

Optional Feature:
- BR_STATS_EN defined:
  - br_count increments on each EVAL→REDIRECT transition (not during hold).
  - taken_count increments on the same transition when taken.
  - Both wrap modulo 2^32 and clear on reset.
- BR_STATS_EN undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- BEQ, rs=rt=0x1234, both ready, target=0x00003010 → stall_id=1 for 2 cycles (IDLE, EVAL); next cycle redirect=1, redirect_pc=0x00003010 for exactly 1 cycle.
- BNE, rs=5, rt=5, ready → 1 EVAL stall; REDIRECT cycle has redirect=0; with BR_STATS_EN, br_count=1 and taken_count=0.
- BGTZ, rs=0x80000000, rs_ready low for 3 cycles then high → stall_id=1 for 3 WAIT cycles plus EVAL; not taken. Repeat with rs=1 → redirect=1.
- JR, rs=0x00400020 after 2-cycle wait → redirect_pc=0x00400020, redirect pulse of 1 cycle; target input ignored.
- rs_ready held low for 20 cycles, MAX_WAIT=15 → wd_err=1 from cycle 16 and stays 1 after rs_ready rises; cleared only by reset.
- Pulse reset in the EVAL cycle of a taken BEQ → next cycle state=IDLE, redirect=0, redirect_pc=0; hold_in=1 during REDIRECT for 2 cycles → redirect stays 0 until release, then a 1-cycle pulse.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Branch/JR resolution sequencer for the ID stage: waits for operands, evaluates, issues one redirect.
// Optional statistics counters are enabled by defining BR_STATS_EN.
module branch_resolve_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [2:0]        br_type,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              rs_ready,
  input  logic              rt_ready,
  input  logic [DATA_W-1:0] target,
  input  logic              hold_in,
  output logic              stall_id,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              wd_err,
  output logic [31:0]       br_count,
  output logic [31:0]       taken_count
);

  typedef enum logic [1:0] {StIdle, StWait, StEval, StRedirect} state_e;

  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);
  localparam logic [3:0] CntMaxC  = 4'hf;

  state_e      state_q;
  logic [3:0]  wait_cnt_q;
  logic        taken_q;
  logic        need_rs, need_rt, ops_ready;
  logic        eq, neg, zero, cond;

  always_comb begin
    need_rs   = (br_type != 3'd7);
    need_rt   = (br_type == 3'd0) || (br_type == 3'd1);
    ops_ready = (!need_rs || rs_ready) && (!need_rt || rt_ready);
    eq        = (rs_val == rt_val);
    neg       = rs_val[DATA_W-1];
    zero      = (rs_val == '0);
    cond      = 1'b0;
    case (br_type)
      3'd0:    cond = eq;
      3'd1:    cond = !eq;
      3'd2:    cond = neg | zero;
      3'd3:    cond = !neg & !zero;
      3'd4:    cond = neg;
      3'd5:    cond = !neg;
      3'd6:    cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      taken_q     <= 1'b0;
      redirect_pc <= '0;
      wd_err      <= 1'b0;
    end else if (!hold_in) begin
      case (state_q)
        StIdle: begin
          if (br_valid) state_q <= ops_ready ? StEval : StWait;
        end
        StWait: begin
          if (!br_valid) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
          end else begin
            if (wait_cnt_q == MaxWaitC) wd_err <= 1'b1;
            if (wait_cnt_q != CntMaxC) wait_cnt_q <= wait_cnt_q + 4'd1;
            if (ops_ready) state_q <= StEval;
          end
        end
        StEval: begin
          wait_cnt_q <= '0;
          if (!br_valid) begin
            state_q <= StIdle;
          end else begin
            taken_q     <= cond;
            redirect_pc <= (br_type == 3'd6) ? rs_val : target;
            state_q     <= StRedirect;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // In IDLE the branch must be held from its very first ID cycle, hence the combinational term.
  assign stall_id = hold_in | ((state_q == StIdle) ? br_valid : (state_q != StRedirect));
  assign redirect = (state_q == StRedirect) & taken_q & !hold_in;

`ifdef BR_STATS_EN
  logic [31:0] br_cnt_q, taken_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (!hold_in && state_q == StEval && br_valid) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (cond) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign br_count    = br_cnt_q;
  assign taken_count = taken_cnt_q;
`else
  assign br_count    = '0;
  assign taken_count = '0;
`endif

endmodule
